avalon_pio_master: RTL
======================

# avalon_pio_master

Avalon-MM master that turns a simple command/response stream into single-beat read and write transfers on the Qsys PIO slaves, such as the chip-select output port. It sits between a control FSM (for example the danmaku frame loader) and the PIO bus segment. It serialises accesses, honours `waitrequest`, and aborts a hung transfer with a timeout error.

## Interface
Parameters:
- `ADDR_W`, 2: slave address width.
- `DATA_W`, 32: data width.
- `TIMEOUT`, 255: maximum number of cycles `waitrequest` may stay high before the transfer is aborted (≥1).

Ports:
- `clk`  in  1: clock.
- `reset_n`  in  1: reset, asynchronous, active-low.
- `cmd_valid`  in  1: command present.
- `cmd_ready`  out  1: master can accept a command.
- `cmd_write`  in  1: 1 = write, 0 = read.
- `cmd_addr`  in  ADDR_W: target address.
- `cmd_wdata`  in  DATA_W: write data.
- `rsp_valid`  out  1: single-cycle response strobe.
- `rsp_rdata`  out  DATA_W: read data; 0 for writes and for errors.
- `rsp_err`  out  1: timeout flag; qualified by `rsp_valid`.
- `avm_address`  out  ADDR_W: bus address.
- `avm_chipselect`  out  1: bus select.
- `avm_write_n`  out  1: active-low write strobe.
- `avm_read_n`  out  1: active-low read strobe.
- `avm_writedata`  out  DATA_W: bus write data.
- `avm_readdata`  in  DATA_W: bus read data; valid in the cycle `waitrequest` is low.
- `avm_waitrequest`  in  1: slave stall.

## Operation
- State machine: IDLE, ACCESS, RESP. Reset state is IDLE.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`&`cmd_ready`, latch write/addr/wdata, clear the timeout counter, go to ACCESS.
- ACCESS:
  - Drive `avm_chipselect`=1 and `avm_address`/`avm_writedata` from the latched values.
  - Drive `avm_write_n`=!write and `avm_read_n`=write.
  - Hold all bus outputs stable while `avm_waitrequest`=1.
  - When `avm_waitrequest`=0: the transfer completes this cycle. Register `avm_readdata` into `rsp_rdata` for a read, or 0 for a write. Set `rsp_err`=0 and go to RESP.
  - When `avm_waitrequest`=1 and counter==TIMEOUT-1: abort. Set `rsp_rdata`=0 and `rsp_err`=1, then go to RESP. Otherwise increment the counter (width clog2(TIMEOUT+1), no wrap).
- RESP:
  - `rsp_valid`=1 for exactly one cycle, then go to IDLE.
  - There is no response backpressure; the consumer must take it.
- Outside ACCESS:
  - `avm_chipselect`=0, `avm_write_n`=1, `avm_read_n`=1.
  - `avm_address`/`avm_writedata` hold their last values; they are don't-care.
- `cmd_ready`=0 in ACCESS and RESP. A command presented there waits, and inputs are not sampled.
- `rsp_rdata`/`rsp_err` hold their values after RESP until the next completion.
- Exactly one response per accepted command. Never two bus transfers in flight.

## Timing
- Reset values: `cmd_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `avm_chipselect`=0, `avm_write_n`=1, `avm_read_n`=1, `avm_address`=0, `avm_writedata`=0.
- All outputs are registered or decoded from state only. There is no combinational path from `cmd_*` or `avm_*` inputs to outputs.
- Command accepted at edge N:
  - Bus asserted cycles N+1 onward.
  - With zero wait states, the bus is asserted only in cycle N+1.
  - `rsp_valid` is high in cycle N+2.
  - `cmd_ready` is high again in cycle N+3.
- Each wait-state cycle adds one cycle to the response latency.
- Timeout: bus asserted for exactly TIMEOUT cycles, `rsp_valid`+`rsp_err` in the next cycle.
- If `waitrequest` drops in the same cycle the counter hits TIMEOUT-1, this is a normal completion (`rsp_err`=0). Completion has priority over timeout.
- Throughput: one transfer per 3 cycles minimum.
- `reset_n` asserted mid-ACCESS or mid-RESP:
  - Outputs go to reset values immediately (asynchronous).
  - The transfer is dropped with no response.
  - After deassertion, the block is in IDLE with `cmd_ready`=1 on the first edge.

## Test plan
- Write, zero wait: cmd write addr 0 data 0x1 -> cycle N+1 `chipselect`=1, `write_n`=0, `address`=0, `writedata`=0x1; N+2 `rsp_valid`=1, `rsp_err`=0, `rsp_rdata`=0; a PIO model reads back `out_port`=1.
- Read with 3 wait states: slave returns 0xA5A5_0001 when `waitrequest` drops -> bus held 4 cycles with stable address, `read_n`=0; `rsp_rdata`=0xA5A5_0001 one cycle later.
- Timeout with TIMEOUT=4 and `waitrequest` stuck at 1 -> bus asserted exactly 4 cycles, then `rsp_valid`=1, `rsp_err`=1, `rsp_rdata`=0; next command is accepted normally.
- Boundary with TIMEOUT=4: `waitrequest` drops in the 4th bus cycle -> `rsp_err`=0 and data captured.
- Back-to-back with `cmd_valid` held for 3 commands -> accepted at N, N+3, N+6; exactly 3 `rsp_valid` pulses, in order.
- Reset mid-transfer: `reset_n` low during ACCESS with wait states -> `chipselect`=0 and `read_n`=1 asynchronously; no `rsp_valid`; `cmd_ready`=1 after release.

Source files
------------

// File: rtl/avalon_pio_master.sv
// Avalon-MM single-beat master for PIO slaves: serialises command/response
// transfers, honours waitrequest and aborts hung transfers with a timeout error.
module avalon_pio_master #(
   parameter int unsigned ADDR_W  = 2,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_chipselect,
   output logic              avm_write_n,
   output logic              avm_read_n,
   output logic [DATA_W-1:0] avm_writedata,
   input  logic [DATA_W-1:0] avm_readdata,
   input  logic              avm_waitrequest
);

   localparam int unsigned     CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_t;

   state_t              state_q, state_d;
   logic                write_q, write_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                err_q, err_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      write_d = write_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               write_d = cmd_write;
               addr_d  = cmd_addr;
               wdata_d = cmd_wdata;
               cnt_d   = '0;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            // Completion is checked first so a late drop of waitrequest wins over timeout.
            if (!avm_waitrequest) begin
               rdata_d = write_q ? '0 : avm_readdata;
               err_d   = 1'b0;
               state_d = RESP;
            end else if (cnt_q == CNT_LAST) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign cmd_ready      = (state_q == IDLE);
   assign rsp_valid      = (state_q == RESP);
   assign rsp_rdata      = rdata_q;
   assign rsp_err        = err_q;
   assign avm_chipselect = (state_q == ACCESS);
   assign avm_write_n    = !((state_q == ACCESS) && write_q);
   assign avm_read_n     = !((state_q == ACCESS) && !write_q);
   assign avm_address    = addr_q;
   assign avm_writedata  = wdata_q;

endmodule
